axi_rw_arbiter: RTL and testbench

//  Shares the single axi_rw bridge port between the IF (fetch, read-only) and MEM (load/store) requesters.
//  Two-way round-robin grant, held until the bridge completes. Exactly one transaction is in flight.

---
 rtl/axi_rw_arbiter_pkg.sv | 41 ++++
 rtl/axi_rw_arbiter_if.sv | 47 ++++
 rtl/axi_rw_arbiter.sv | 148 ++++++++++++++
 tb/tb_axi_rw_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rw_arbiter_pkg.sv
// Shared types and encodings for the IF/MEM arbiter in front of the axi_rw bridge.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE   = 2'b00;
    localparam logic [1:0] GNT_IF_OH  = 2'b01;
    localparam logic [1:0] GNT_MEM_OH = 2'b10;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic LAST_IF  = 1'b0;
    localparam logic LAST_MEM = 1'b1;

    // A tie goes to whichever requester was not served last.
    function automatic arb_state_t pick_owner(input logic if_valid,
                                              input logic mem_valid,
                                              input logic last_grant);
        arb_state_t owner;
        if (if_valid && mem_valid) begin
            if (last_grant == LAST_MEM) begin
                owner = GNT_IF;
            end else begin
                owner = GNT_MEM;
            end
        end else if (if_valid) begin
            owner = GNT_IF;
        end else if (mem_valid) begin
            owner = GNT_MEM;
        end else begin
            owner = IDLE;
        end
        return owner;
    endfunction

endpackage

// File: rtl/axi_rw_arbiter_if.sv
// Requester and bridge signal bundle around the arbiter; slave = arbiter view.
interface axi_rw_arbiter_if #(
    parameter int RW_DATA_WIDTH = 64,
    parameter int RW_ADDR_WIDTH = 32
);
    logic                     if_valid_i;
    logic                     if_ready_o;
    logic [RW_ADDR_WIDTH-1:0] if_addr_i;
    logic [7:0]               if_size_i;
    logic [RW_DATA_WIDTH-1:0] if_data_o;

    logic                     mem_valid_i;
    logic                     mem_ready_o;
    logic                     mem_req_i;
    logic [RW_ADDR_WIDTH-1:0] mem_addr_i;
    logic [RW_DATA_WIDTH-1:0] mem_w_data_i;
    logic [7:0]               mem_size_i;
    logic [RW_DATA_WIDTH-1:0] mem_data_o;

    logic                     rw_valid_o;
    logic                     rw_ready_i;
    logic                     rw_req_o;
    logic [RW_ADDR_WIDTH-1:0] rw_addr_o;
    logic [RW_DATA_WIDTH-1:0] rw_w_data_o;
    logic [7:0]               rw_size_o;
    logic [RW_DATA_WIDTH-1:0] rw_data_read_i;

    logic [1:0]               grant_o;

    modport slave (
        input  if_valid_i, if_addr_i, if_size_i,
        input  mem_valid_i, mem_req_i, mem_addr_i, mem_w_data_i, mem_size_i,
        input  rw_ready_i, rw_data_read_i,
        output if_ready_o, if_data_o, mem_ready_o, mem_data_o,
        output rw_valid_o, rw_req_o, rw_addr_o, rw_w_data_o, rw_size_o,
        output grant_o
    );

    modport master (
        output if_valid_i, if_addr_i, if_size_i,
        output mem_valid_i, mem_req_i, mem_addr_i, mem_w_data_i, mem_size_i,
        output rw_ready_i, rw_data_read_i,
        input  if_ready_o, if_data_o, mem_ready_o, mem_data_o,
        input  rw_valid_o, rw_req_o, rw_addr_o, rw_w_data_o, rw_size_o,
        input  grant_o
    );
endinterface

// File: rtl/axi_rw_arbiter.sv
// Round-robin arbiter sharing one axi_rw bridge between IF (fetch) and MEM (load/store).
module axi_rw_arbiter
    import axi_arb_pkg::*;
#(
    parameter int RW_DATA_WIDTH = 64,
    parameter int RW_ADDR_WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    axi_rw_arbiter_if.slave  bus
);

    arb_state_t               state_r;
    arb_state_t               state_next_s;
    logic                     last_grant_r;
    logic                     last_grant_next_s;
    logic [RW_DATA_WIDTH-1:0] if_data_r;
    logic [RW_DATA_WIDTH-1:0] mem_data_r;
    logic                     if_done_s;
    logic                     mem_done_s;
    logic                     mem_is_read_s;

    assign mem_is_read_s = (bus.mem_req_i == RW_READ);

    // Completion of the owner's transaction; a bridge pulse while idle is dropped.
    always_comb begin
        if_done_s  = 1'b0;
        mem_done_s = 1'b0;
        if (!reset && bus.rw_ready_i) begin
            case (state_r)
                GNT_IF:  if_done_s  = 1'b1;
                GNT_MEM: mem_done_s = 1'b1;
                default: begin
                    if_done_s  = 1'b0;
                    mem_done_s = 1'b0;
                end
            endcase
        end else begin
            if_done_s  = 1'b0;
            mem_done_s = 1'b0;
        end
    end

    // Next owner: grant only from IDLE, release only on bridge completion.
    always_comb begin
        state_next_s      = state_r;
        last_grant_next_s = last_grant_r;
        case (state_r)
            IDLE: begin
                state_next_s = pick_owner(bus.if_valid_i, bus.mem_valid_i, last_grant_r);
            end
            GNT_IF: begin
                if (bus.rw_ready_i) begin
                    state_next_s      = IDLE;
                    last_grant_next_s = LAST_IF;
                end else begin
                    state_next_s = GNT_IF;
                end
            end
            GNT_MEM: begin
                if (bus.rw_ready_i) begin
                    state_next_s      = IDLE;
                    last_grant_next_s = LAST_MEM;
                end else begin
                    state_next_s = GNT_MEM;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, round-robin pointer and per-port held read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= LAST_MEM;
            if_data_r    <= '0;
            mem_data_r   <= '0;
        end else begin
            state_r      <= state_next_s;
            last_grant_r <= last_grant_next_s;
            if (if_done_s) begin
                if_data_r <= bus.rw_data_read_i;
            end
            if (mem_done_s && mem_is_read_s) begin
                mem_data_r <= bus.rw_data_read_i;
            end
        end
    end

    // Payload mux to the bridge and completion routing back to the owner.
    always_comb begin
        bus.grant_o     = GNT_NONE;
        bus.rw_valid_o  = 1'b0;
        bus.rw_req_o    = RW_READ;
        bus.rw_addr_o   = '0;
        bus.rw_w_data_o = '0;
        bus.rw_size_o   = 8'h00;
        bus.if_ready_o  = 1'b0;
        bus.mem_ready_o = 1'b0;
        if (reset) begin
            bus.grant_o = GNT_NONE;
        end else begin
            case (state_r)
                GNT_IF: begin
                    bus.grant_o    = GNT_IF_OH;
                    bus.rw_valid_o = bus.if_valid_i;
                    bus.rw_req_o   = RW_READ;
                    bus.rw_addr_o  = bus.if_addr_i;
                    bus.rw_size_o  = bus.if_size_i;
                    bus.if_ready_o = bus.rw_ready_i;
                end
                GNT_MEM: begin
                    bus.grant_o     = GNT_MEM_OH;
                    bus.rw_valid_o  = bus.mem_valid_i;
                    bus.rw_req_o    = bus.mem_req_i;
                    bus.rw_addr_o   = bus.mem_addr_i;
                    bus.rw_w_data_o = bus.mem_w_data_i;
                    bus.rw_size_o   = bus.mem_size_i;
                    bus.mem_ready_o = bus.rw_ready_i;
                end
                default: bus.grant_o = GNT_NONE;
            endcase
        end
    end

    // Read data: live bridge data on the completion cycle, held copy otherwise.
    always_comb begin
        bus.if_data_o  = if_data_r;
        bus.mem_data_o = mem_data_r;
        if (reset) begin
            bus.if_data_o  = '0;
            bus.mem_data_o = '0;
        end else begin
            if (if_done_s) begin
                bus.if_data_o = bus.rw_data_read_i;
            end else begin
                bus.if_data_o = if_data_r;
            end
            if (mem_done_s && mem_is_read_s) begin
                bus.mem_data_o = bus.rw_data_read_i;
            end else begin
                bus.mem_data_o = mem_data_r;
            end
        end
    end

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Self-checking bench for axi_rw_arbiter: vector table, directed corner cases, random vs reference model.
module tb_axi_rw_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    axi_rw_arbiter_if #(.RW_DATA_WIDTH(64), .RW_ADDR_WIDTH(32)) bus ();

    axi_rw_arbiter #(.RW_DATA_WIDTH(64), .RW_ADDR_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Protocol monitors: bridge completion only while someone owns the port, and
    // the owner must keep its request up until it is served.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(bus.rw_ready_i && bus.grant_o == 2'b00)) else begin
                errors++;
                $display("FAIL idle_ready: rw_ready_i seen with grant_o %b", bus.grant_o);
            end
            assert (!(bus.grant_o == 2'b01 && !bus.if_valid_i) && !(bus.grant_o == 2'b10 && !bus.mem_valid_i)) else begin
                errors++;
                $display("FAIL valid_drop: owner dropped valid, grant_o %b", bus.grant_o);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_valid_i     = 1'b0;
        bus.if_addr_i      = 32'h0;
        bus.if_size_i      = 8'h00;
        bus.mem_valid_i    = 1'b0;
        bus.mem_req_i      = 1'b0;
        bus.mem_addr_i     = 32'h0;
        bus.mem_w_data_i   = 64'h0;
        bus.mem_size_i     = 8'h00;
        bus.rw_ready_i     = 1'b0;
        bus.rw_data_read_i = 64'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Raise a request, wait (bounded) for its grant, check payload, complete after lat cycles.
    task automatic run_txn(input bit is_mem, input logic req, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [7:0] size,
                           input logic [63:0] rdata, input int lat, input string tag);
        int n;
        if (is_mem) begin
            bus.mem_valid_i  = 1'b1;
            bus.mem_req_i    = req;
            bus.mem_addr_i   = addr;
            bus.mem_w_data_i = wdata;
            bus.mem_size_i   = size;
        end else begin
            bus.if_valid_i = 1'b1;
            bus.if_addr_i  = addr;
            bus.if_size_i  = size;
        end
        n = 0;
        while (bus.grant_o == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " grant"}, 64'(bus.grant_o), is_mem ? 64'h2 : 64'h1);
        check({tag, " rw_valid"}, 64'(bus.rw_valid_o), 64'h1);
        check({tag, " rw_req"}, 64'(bus.rw_req_o), is_mem ? 64'(req) : 64'h0);
        check({tag, " rw_addr"}, 64'(bus.rw_addr_o), 64'(addr));
        check({tag, " rw_w_data"}, bus.rw_w_data_o, is_mem ? wdata : 64'h0);
        check({tag, " rw_size"}, 64'(bus.rw_size_o), 64'(size));
        repeat (lat) begin
            check({tag, " early_ready"}, 64'({bus.mem_ready_o, bus.if_ready_o}), 64'h0);
            tick();
        end
        bus.rw_ready_i     = 1'b1;
        bus.rw_data_read_i = rdata;
        #1;
        check({tag, " ready"}, 64'({bus.mem_ready_o, bus.if_ready_o}), is_mem ? 64'h2 : 64'h1);
        tick();
        bus.rw_ready_i     = 1'b0;
        bus.rw_data_read_i = 64'h0;
        bus.if_valid_i     = is_mem ? bus.if_valid_i : 1'b0;
        bus.mem_valid_i    = is_mem ? 1'b0 : bus.mem_valid_i;
        #1;
        check({tag, " ready_pulse"}, 64'({bus.mem_ready_o, bus.if_ready_o}), 64'h0);
        check({tag, " grant_after"}, 64'(bus.grant_o), 64'h0);
    endtask

    typedef struct {
        logic        iv, mv, mreq, rdy;
        logic [63:0] rdata;
        logic [1:0]  e_grant;
        logic        e_valid, e_req, e_ifr, e_memr;
        logic [63:0] e_ifd, e_memd;
    } vec_t;

    vec_t vecs [12];

    // Reference model state for the random phase.
    int          owner;
    int          last_owner;
    int          lat;
    bit          pend_if, pend_mem;
    logic [31:0] p_if_addr, p_mem_addr;
    logic [7:0]  p_if_size, p_mem_size;
    logic        p_mem_req;
    logic [63:0] p_mem_wdata;
    logic [63:0] m_if_held, m_mem_held;
    logic        rdy;
    logic [63:0] rdata;

    initial begin
        // iv mv mreq rdy rdata | grant valid req ifr memr if_data mem_data
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'hA, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 64'hA, 64'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA, 64'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'hB, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 64'hA, 64'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA, 64'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 64'hA, 64'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 64'hC, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA, 64'hC};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA, 64'hC};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'hD, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 64'hD, 64'hC};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'hD, 64'hC};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'hD, 64'hC};

        do_reset();
        check("reset grant", 64'(bus.grant_o), 64'h0);
        check("reset rw_valid", 64'(bus.rw_valid_o), 64'h0);
        check("reset if_data", bus.if_data_o, 64'h0);
        check("reset mem_data", bus.mem_data_o, 64'h0);

        // Vector table
        bus.if_addr_i    = 32'h0000_0100;
        bus.if_size_i    = 8'h0F;
        bus.mem_addr_i   = 32'h0000_0200;
        bus.mem_w_data_i = 64'h55;
        bus.mem_size_i   = 8'hF0;
        for (int i = 0; i < 12; i++) begin
            bus.if_valid_i     = vecs[i].iv;
            bus.mem_valid_i    = vecs[i].mv;
            bus.mem_req_i      = vecs[i].mreq;
            bus.rw_ready_i     = vecs[i].rdy;
            bus.rw_data_read_i = vecs[i].rdata;
            #1;
            check($sformatf("vec%0d grant", i), 64'(bus.grant_o), 64'(vecs[i].e_grant));
            check($sformatf("vec%0d rw_valid", i), 64'(bus.rw_valid_o), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d rw_req", i), 64'(bus.rw_req_o), 64'(vecs[i].e_req));
            check($sformatf("vec%0d ready", i), 64'({bus.mem_ready_o, bus.if_ready_o}),
                  64'({vecs[i].e_memr, vecs[i].e_ifr}));
            check($sformatf("vec%0d if_data", i), bus.if_data_o, vecs[i].e_ifd);
            check($sformatf("vec%0d mem_data", i), bus.mem_data_o, vecs[i].e_memd);
            tick();
        end

        // Reset in the middle of a granted MEM write
        do_reset();
        bus.mem_valid_i  = 1'b1;
        bus.mem_req_i    = 1'b1;
        bus.mem_addr_i   = 32'h8000_1000;
        bus.mem_w_data_i = 64'h1234;
        bus.mem_size_i   = 8'hFF;
        tick();
        check("midrst granted", 64'(bus.grant_o), 64'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem_valid_i = 1'b0;
        #1;
        check("midrst grant", 64'(bus.grant_o), 64'h0);
        check("midrst rw_valid", 64'(bus.rw_valid_o), 64'h0);
        check("midrst rw_req", 64'(bus.rw_req_o), 64'h0);
        run_txn(1'b0, 1'b0, 32'h8000_0040, 64'h0, 8'h0F, 64'h77, 1, "midrst_if");
        check("midrst if_data", bus.if_data_o, 64'h77);

        // IF only, bridge answers after 3 cycles
        do_reset();
        run_txn(1'b0, 1'b0, 32'h8000_0000, 64'h0, 8'h0F, 64'h0000_0013_0000_0093, 2, "if_only");
        check("if_only data", bus.if_data_o, 64'h0000_0013_0000_0093);
        tick();
        check("if_only held", bus.if_data_o, 64'h0000_0013_0000_0093);
        check("if_only mem_data", bus.mem_data_o, 64'h0);

        // Isolation of held read data, then MEM write leaves mem_data_o alone
        do_reset();
        run_txn(1'b0, 1'b0, 32'h0000_1000, 64'h0, 8'h0F, 64'h1111, 0, "iso_if");
        run_txn(1'b1, 1'b0, 32'h0000_2000, 64'h0, 8'hFF, 64'h2222, 1, "iso_mem");
        check("iso if_data", bus.if_data_o, 64'h1111);
        check("iso mem_data", bus.mem_data_o, 64'h2222);
        run_txn(1'b1, 1'b1, 32'h8000_1000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h9999, 1, "mem_wr");
        check("mem_wr mem_data", bus.mem_data_o, 64'h2222);
        check("mem_wr if_data", bus.if_data_o, 64'h1111);

        // Both continuously valid: strict alternation, one idle cycle between grants
        do_reset();
        bus.if_valid_i  = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.mem_req_i   = 1'b0;
        for (int t = 0; t < 6; t++) begin
            int gap;
            gap = 0;
            while (bus.grant_o == 2'b00 && gap < 10) begin
                tick();
                gap++;
            end
            check($sformatf("rr%0d gap", t), 64'(gap), 64'h1);
            check($sformatf("rr%0d grant", t), 64'(bus.grant_o), (t % 2 == 0) ? 64'h1 : 64'h2);
            bus.rw_ready_i     = 1'b1;
            bus.rw_data_read_i = 64'(t);
            tick();
            bus.rw_ready_i = 1'b0;
        end
        bus.if_valid_i  = 1'b0;
        bus.mem_valid_i = 1'b0;

        // Random traffic against a transaction-level model
        do_reset();
        owner      = -1;
        last_owner = 1;
        lat        = 0;
        pend_if    = 1'b0;
        pend_mem   = 1'b0;
        m_if_held  = 64'h0;
        m_mem_held = 64'h0;
        p_if_addr = 32'h0; p_if_size = 8'h00;
        p_mem_addr = 32'h0; p_mem_size = 8'h00; p_mem_req = 1'b0; p_mem_wdata = 64'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [63:0] e_if_data, e_mem_data;
            if (!pend_if && $urandom_range(0, 2) == 0) begin
                pend_if   = 1'b1;
                p_if_addr = $urandom;
                p_if_size = 8'($urandom_range(0, 255));
            end
            if (!pend_mem && $urandom_range(0, 2) == 0) begin
                pend_mem    = 1'b1;
                p_mem_req   = 1'($urandom_range(0, 1));
                p_mem_addr  = $urandom;
                p_mem_wdata = {$urandom, $urandom};
                p_mem_size  = 8'($urandom_range(0, 255));
            end
            bus.if_valid_i   = pend_if;
            bus.if_addr_i    = p_if_addr;
            bus.if_size_i    = p_if_size;
            bus.mem_valid_i  = pend_mem;
            bus.mem_req_i    = p_mem_req;
            bus.mem_addr_i   = p_mem_addr;
            bus.mem_w_data_i = p_mem_wdata;
            bus.mem_size_i   = p_mem_size;
            rdy   = 1'b0;
            rdata = {$urandom, $urandom};
            if (owner >= 0) begin
                if (lat == 0) rdy = 1'b1;
                else lat--;
            end
            bus.rw_ready_i     = rdy;
            bus.rw_data_read_i = rdata;
            #1;
            e_if_data  = (owner == 0 && rdy) ? rdata : m_if_held;
            e_mem_data = (owner == 1 && rdy && !p_mem_req) ? rdata : m_mem_held;
            check("rnd grant", 64'(bus.grant_o), owner == 0 ? 64'h1 : (owner == 1 ? 64'h2 : 64'h0));
            check("rnd rw_valid", 64'(bus.rw_valid_o), 64'(owner >= 0));
            check("rnd rw_req", 64'(bus.rw_req_o), owner == 1 ? 64'(p_mem_req) : 64'h0);
            check("rnd rw_addr", 64'(bus.rw_addr_o),
                  owner == 0 ? 64'(p_if_addr) : (owner == 1 ? 64'(p_mem_addr) : 64'h0));
            check("rnd rw_w_data", bus.rw_w_data_o, owner == 1 ? p_mem_wdata : 64'h0);
            check("rnd rw_size", 64'(bus.rw_size_o),
                  owner == 0 ? 64'(p_if_size) : (owner == 1 ? 64'(p_mem_size) : 64'h0));
            check("rnd ready", 64'({bus.mem_ready_o, bus.if_ready_o}),
                  64'({owner == 1 && rdy, owner == 0 && rdy}));
            check("rnd if_data", bus.if_data_o, e_if_data);
            check("rnd mem_data", bus.mem_data_o, e_mem_data);
            if (owner >= 0 && rdy) begin
                if (owner == 0) begin
                    m_if_held = rdata;
                    pend_if   = 1'b0;
                end else begin
                    if (!p_mem_req) m_mem_held = rdata;
                    pend_mem = 1'b0;
                end
                last_owner = owner;
                owner      = -1;
            end else if (owner < 0) begin
                if (pend_if && pend_mem) owner = 1 - last_owner;
                else if (pend_if) owner = 0;
                else if (pend_mem) owner = 1;
                if (owner >= 0) lat = $urandom_range(0, 3);
            end
            @(posedge clock);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
